// File: rtl/fp_multiplier_radix_pkg.sv
// Shared FP definitions: rounding-mode constants, FSM encoding, exponent bias helper.
package fp_multiplier_radix_pkg;

    localparam int RM_HALFUP = 0;
    localparam int RM_RNE    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_multiplier_radix_round_pack.sv
// Combinational normalise/round/pack of a raw significand product, with IEEE-style
// overflow to infinity and flush-to-zero on underflow.
module fp_multiplier_radix_round_pack
    import fp_multiplier_radix_pkg::*;
#(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int RMODE = RM_HALFUP
) (
    input  logic [2*MW+1:0] p_i,
    input  logic [EW+1:0]   esum_i,
    input  logic            sign_i,
    input  logic            zero_i,
    output logic [EW+MW:0]  z_o,
    output logic            ovf_o,
    output logic            unf_o
);
    localparam int SW = MW + 1;
    localparam int PW = 2 * SW;

    logic          norm, guard, sticky, inc, rcarry, uflow, oflow;
    logic [MW-1:0] frac;
    logic [MW:0]   msum;
    logic [EW+1:0] e;

    // The hidden bit sits at PW-1 or PW-2; only the fraction below it is rounded.
    assign norm   = p_i[PW-1];
    assign frac   = norm ? p_i[PW-2:SW] : p_i[PW-3:SW-1];
    assign guard  = norm ? p_i[SW-1]    : p_i[SW-2];
    assign sticky = norm ? |p_i[SW-2:0] : |p_i[SW-3:0];
    assign inc    = (RMODE == RM_RNE) ? (guard & (sticky | frac[0])) : guard;
    assign msum   = {1'b0, frac} + (MW+1)'(inc);
    assign rcarry = msum[MW];
    assign e      = esum_i + (EW+2)'(norm) + (EW+2)'(rcarry);
    assign uflow  = e[EW+1] | (e == '0);
    assign oflow  = ~e[EW+1] & (e[EW:0] >= (EW+1)'((1 << EW) - 1));

    always_comb begin
        z_o   = '0;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (!zero_i) begin
            if (uflow) begin
                unf_o = 1'b1;
            end else if (oflow) begin
                ovf_o = 1'b1;
                z_o   = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
            end else begin
                z_o   = {sign_i, e[EW-1:0], msum[MW-1:0]};
            end
        end
    end

endmodule

// File: rtl/fp_multiplier_radix.sv
// Iterative radix-2^BPC floating-point multiplier behind a run/stall handshake.
module fp_multiplier_radix
    import fp_multiplier_radix_pkg::*;
#(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int BPC   = 1,
    parameter int RMODE = RM_HALFUP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [EW+MW:0] x,
    input  logic [EW+MW:0] y,
    output logic           stall,
    output logic [EW+MW:0] z,
    output logic           ovf,
    output logic           unf
);
    localparam int SW = MW + 1;
    localparam int PW = 2 * SW;
    localparam int AW = SW + BPC;
    localparam int N  = (SW + BPC - 1) / BPC;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    fsm_state_e     state_q;
    logic [CW-1:0]  cnt_q;
    logic [PW-1:0]  p_q, p_step;
    logic [AW-1:0]  psum;
    logic [EW+1:0]  esum;
    logic           zero_op;
    logic [EW+MW:0] z_q, rp_z;
    logic           ovf_q, unf_q, rp_ovf, rp_unf;

    // Upper half accumulates BPC multiplier bits at a time; the adder is wide enough to keep the carry.
    assign psum    = AW'(p_q[PW-1:SW]) + AW'(p_q[BPC-1:0]) * AW'({1'b1, y[MW-1:0]});
    assign p_step  = {psum, p_q[SW-1:BPC]};
    assign esum    = (EW+2)'(x[EW+MW-1:MW]) + (EW+2)'(y[EW+MW-1:MW]) - (EW+2)'(fp_bias(EW));
    assign zero_op = ~|x[EW+MW-1:MW] | ~|y[EW+MW-1:MW];

    fp_multiplier_radix_round_pack #(.EW(EW), .MW(MW), .RMODE(RMODE)) u_round_pack (
        .p_i    (p_step),
        .esum_i (esum),
        .sign_i (x[EW+MW] ^ y[EW+MW]),
        .zero_i (zero_op),
        .z_o    (rp_z),
        .ovf_o  (rp_ovf),
        .unf_o  (rp_unf)
    );

    // The IDLE cycle that sees run loads P, and LOAD already retires the first
    // multiplier bits, so the stall window is N+1 cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!run) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    p_q     <= {{SW{1'b0}}, 1'b1, x[MW-1:0]};
                    cnt_q   <= '0;
                    state_q <= ST_LOAD;
                end
                ST_LOAD, ST_MUL: begin
                    p_q   <= p_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        z_q     <= rp_z;
                        ovf_q   <= rp_ovf;
                        unf_q   <= rp_unf;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_MUL;
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall = rst & run & (state_q != ST_DONE);
    assign z     = z_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_fp_multiplier_radix.sv
// Directed and model-checked vectors across BPC in {1,2,4} x RMODE in {0,1}.
module tb_fp_multiplier_radix;
    localparam int NI = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [NI-1:0] stall_w, ovf_w, unf_w;
    logic [31:0] z_w [NI];
    int n_assert = 0;
    int n_fail   = 0;
    int scnt [NI];

    always #5 clk = ~clk;

    // Instance g: BPC = 1,1,2,2,4,4 ; RMODE = g%2
    for (genvar g = 0; g < NI; g++) begin : g_dut
        fp_multiplier_radix #(
            .EW(8), .MW(23),
            .BPC((g / 2 == 0) ? 1 : ((g / 2 == 1) ? 2 : 4)),
            .RMODE(g % 2)
        ) u_dut (
            .clk(clk), .rst(rst), .run(run), .x(x), .y(y),
            .stall(stall_w[g]), .z(z_w[g]), .ovf(ovf_w[g]), .unf(unf_w[g])
        );
    end

    function automatic int exp_stall(input int g);
        return (g / 2 == 0) ? 25 : ((g / 2 == 1) ? 13 : 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        bit busy;
        @(negedge clk);
        x = a; y = b; run = 1'b1;
        for (int g = 0; g < NI; g++) scnt[g] = 0;
        busy = 1'b1;
        for (int c = 0; c < 40 && busy; c++) begin
            #1;
            busy = 1'b0;
            for (int g = 0; g < NI; g++) begin
                if (stall_w[g]) begin
                    scnt[g]++;
                    busy = 1'b1;
                end
            end
            if (busy) @(negedge clk);
        end
        chk("stall_timeout", 32'(busy), 32'd0);
    endtask

    task automatic end_op();
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [31:0] z0, input logic [31:0] z1,
                            input logic o, input logic u);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s z[%0d]", tag, g), z_w[g], (g % 2) ? z1 : z0);
            chk($sformatf("%s ovf[%0d]", tag, g), 32'(ovf_w[g]), 32'(o));
            chk($sformatf("%s unf[%0d]", tag, g), 32'(unf_w[g]), 32'(u));
            chk($sformatf("%s stalls[%0d]", tag, g), 32'(scnt[g]), 32'(exp_stall(g)));
        end
    endtask

    // Reference: full product, then remainder-vs-half rounding; returns {ovf, unf, z}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input int rm);
        logic [47:0] prod, q, rem, half;
        int sh, e;
        bit up, s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 34'd0;
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        sh   = prod[47] ? 24 : 23;
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 48'd1 << (sh - 1);
        up   = (rm == 0) ? (rem >= half) : ((rem > half) || (rem == half && q[0]));
        e    = int'(a[30:23]) + int'(b[30:23]) - 127 + sh - 23;
        if (up) q = q + 48'd1;
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        if (e <= 0) return {2'b01, 32'd0};
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        return {2'b00, s, e[7:0], q[22:0]};
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [33:0] m;

        // Reset with run high: no stall, cleared outputs
        x = 32'h3FC00000; y = 32'h40000000; run = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset stall", 32'(stall_w), 32'd0);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("reset z[%0d]", g), z_w[g], 32'd0);
            chk($sformatf("reset flags[%0d]", g), 32'({ovf_w[g], unf_w[g]}), 32'd0);
        end
        run = 1'b0;
        rst = 1'b1;

        run_op(32'h3FC00000, 32'h40000000); check_op("1.5x2", 32'h40400000, 32'h40400000, 1'b0, 1'b0); end_op();
        run_op(32'h3F800003, 32'h3FC00000); check_op("tie", 32'h3FC00005, 32'h3FC00004, 1'b0, 1'b0); end_op();
        run_op(32'h3F800001, 32'h3F800001); check_op("sq1u", 32'h3F800002, 32'h3F800002, 1'b0, 1'b0); end_op();
        run_op(32'h7F000000, 32'h7F000000); check_op("ovf+", 32'h7F800000, 32'h7F800000, 1'b1, 1'b0); end_op();
        run_op(32'hFF000000, 32'h7F000000); check_op("ovf-", 32'hFF800000, 32'hFF800000, 1'b1, 1'b0); end_op();
        run_op(32'h00800000, 32'h00800000); check_op("unf", 32'h00000000, 32'h00000000, 1'b0, 1'b1); end_op();
        run_op(32'h00000000, 32'h40400000); check_op("zero", 32'h00000000, 32'h00000000, 1'b0, 1'b0); end_op();

        // Abort at cycle 10, then restart must take the full window
        @(negedge clk);
        x = 32'h3FC00000; y = 32'h40000000; run = 1'b1;
        repeat (10) @(negedge clk);
        run = 1'b0;
        #1;
        chk("abort stall", 32'(stall_w), 32'd0);
        run_op(32'h40000000, 32'h40400000); check_op("restart", 32'h40C00000, 32'h40C00000, 1'b0, 1'b0); end_op();

        // Reset mid-op at cycle 5
        @(negedge clk);
        x = 32'h3F800003; y = 32'h3FC00000; run = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset stall", 32'(stall_w), 32'd0);
        @(negedge clk);
        #1;
        chk("midreset z", z_w[0], 32'd0);
        run = 1'b0;
        rst = 1'b1;
        run_op(32'h3FC00000, 32'h3FC00000); check_op("postreset", 32'h40100000, 32'h40100000, 1'b0, 1'b0); end_op();

        // Random operands against the reference model
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) begin
                a[30:23] = 8'(100 + $urandom_range(0, 50));
                b[30:23] = 8'(100 + $urandom_range(0, 50));
            end
            run_op(a, b);
            for (int g = 0; g < NI; g++) begin
                m = model(a, b, g % 2);
                chk($sformatf("rand%0d z[%0d] a=%0h b=%0h", i, g, a, b), z_w[g], m[31:0]);
                chk($sformatf("rand%0d flags[%0d]", i, g), 32'({ovf_w[g], unf_w[g]}), 32'(m[33:32]));
                chk($sformatf("rand%0d stalls[%0d]", i, g), 32'(scnt[g]), 32'(exp_stall(g)));
            end
            end_op();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
